// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, transmitter state encoding,
// the oversample ratio used by both TX and RX, and parity helpers.
// The break-related states exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 8;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
`ifdef UART_TX_BREAK_EN
    ,
    TX_BREAK,
    TX_MAB
`endif
  } tx_state_e;

  // Codes 5..7 are reserved and fall back to "no parity bit".
  function automatic logic par_enabled(input logic [2:0] mode);
    return (mode >= PAR_EVEN) && (mode <= PAR_SPACE);
  endfunction

  // Parity bit value for a mode, given the XOR of all data bits.
  function automatic logic par_value(input logic [2:0] mode, input logic data_xor);
    case (mode)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: loadable down-counter that ticks on the last cycle of
// every period. A load captures the period and restarts the count; the
// captured period is reused on every following tick until the next load.
module uart_bit_timer #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per;

  // Count down from period-1 to 0, then wrap to the captured period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      per <= '0;
    end else if (load) begin
      cnt <= period - CNT_W'(1);
      per <= period;
    end else if (en) begin
      cnt <= tick ? per - CNT_W'(1) : cnt - CNT_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// AXI4-Stream UART transmitter with per-frame parity / stop-bit configuration.
// One word per frame, LSB first, bit period max(prescale,1)*8 clk cycles.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [2:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = PRESCALE_W + 3;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_cfg: DATA_WIDTH must be in 5..9");
  end

  tx_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IW-1:0]         idx;
  logic                  par_en_q, par_bit_q, stop2_q, stop_second_q;
  logic                  rdy_q;
  logic                  tick, accept, timer_load, last_stop, brk;
  logic [CW-1:0]         t_new;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  // prescale 0 is treated as 1
  assign t_new = CW'((prescale == '0) ? PRESCALE_W'(1) : prescale) * CW'(OVERSAMPLE);

  // rdy_q holds tready low through reset and for the reset cycles themselves
  assign s_axis_tready = (state == TX_IDLE) && rdy_q && !brk;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_stop     = tick && (!stop2_q || stop_second_q);
  assign timer_load    = accept
`ifdef UART_TX_BREAK_EN
                       || (state == TX_BREAK && !break_req)
`endif
                       ;

  uart_bit_timer #(.CNT_W(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (busy),
    .period (t_new),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: bit sequencing advances on timer ticks
  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) state_nxt = TX_BREAK;
        else
`endif
        if (accept) state_nxt = TX_START;
      end
      TX_START:  if (tick) state_nxt = TX_DATA;
      TX_DATA:   if (tick && idx == IW'(DATA_WIDTH - 1))
                   state_nxt = par_en_q ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tick) state_nxt = TX_STOP;
      TX_STOP:   if (last_stop) state_nxt = TX_IDLE;
`ifdef UART_TX_BREAK_EN
      TX_BREAK:  if (!break_req) state_nxt = TX_MAB;
      TX_MAB:    if (tick) state_nxt = TX_IDLE;
`endif
      default:   state_nxt = TX_IDLE;
    endcase
  end

  // Frame datapath: latch word and config on accept, shift data per bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q         <= 1'b0;
      data_q        <= '0;
      idx           <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        data_q        <= s_axis_tdata;
        idx           <= '0;
        par_en_q      <= par_enabled(cfg_parity);
        par_bit_q     <= par_value(cfg_parity, ^s_axis_tdata);
        stop2_q       <= cfg_stop2;
        stop_second_q <= 1'b0;
      end else if (tick) begin
        if (state == TX_DATA) begin
          data_q <= data_q >> 1;
          idx    <= idx + IW'(1);
        end
        if (state == TX_STOP) stop_second_q <= 1'b1;
      end
    end
  end

  // Line level and busy decode from state
  always_comb begin
    txd  = 1'b1;
    busy = 1'b1;
    case (state)
      TX_IDLE:   busy = 1'b0;
      TX_START:  txd  = 1'b0;
      TX_DATA:   txd  = data_q[0];
      TX_PARITY: txd  = par_bit_q;
`ifdef UART_TX_BREAK_EN
      TX_BREAK:  txd  = 1'b0;
`endif
      default:   txd  = 1'b1;
    endcase
  end

  assign frame_done = (state == TX_STOP) && last_stop;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames from the test plan
// plus randomized frames, compared cycle by cycle against a bit-list model.
// Define UART_TX_BREAK_EN to also exercise the break feature.
module tb_uart_tx_cfg;
  localparam int DW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [2:0]    cfg_parity = 3'd0;
  logic          cfg_stop2 = 1'b0;
  logic [PW-1:0] prescale = PW'(1);
`ifdef UART_TX_BREAK_EN
  logic          break_req = 1'b0;
`endif
  logic          txd, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .prescale      (prescale),
`ifdef UART_TX_BREAK_EN
    .break_req     (break_req),
`endif
    .txd           (txd),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait for acceptance, then check every cycle of the frame
  // against the expected bit list. Inputs are scrambled right after accept
  // to show the frame uses only the values latched at accept.
  task automatic send_frame(input logic [DW-1:0] d, input int par, input bit s2,
                            input int pre, input bit hold_valid, output int start_cyc);
    int t, n, waited;
    bit exp_bits[$];
    s_axis_tdata  = d;
    cfg_parity    = 3'(par);
    cfg_stop2     = s2;
    prescale      = PW'(pre);
    s_axis_tvalid = 1'b1;
    waited = 0;
    while (s_axis_tready !== 1'b1 && waited < 400) begin
      step();
      waited++;
    end
    check("tready_before_accept", 32'(s_axis_tready), 32'd1);
    start_cyc = -1;
    if (s_axis_tready !== 1'b1) return;
    step();
    start_cyc = cyc;
    if (!hold_valid) s_axis_tvalid = 1'b0;
    cfg_parity   = 3'($urandom);
    cfg_stop2    = 1'($urandom);
    prescale     = PW'($urandom_range(0, 5));
    s_axis_tdata = DW'($urandom);

    t = ((pre == 0) ? 1 : pre) * 8;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    case (par)
      1: exp_bits.push_back(($countones(d) % 2) == 1);
      2: exp_bits.push_back(($countones(d) % 2) == 0);
      3: exp_bits.push_back(1'b1);
      4: exp_bits.push_back(1'b0);
      default: ;
    endcase
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
    n = exp_bits.size();

    for (int c = 0; c < n * t; c++) begin
      check($sformatf("txd d=%0h c=%0d", d, c), 32'(txd), 32'(exp_bits[c / t]));
      check($sformatf("busy c=%0d", c), 32'(busy), 32'd1);
      check($sformatf("tready c=%0d", c), 32'(s_axis_tready), 32'd0);
      check($sformatf("frame_done c=%0d", c), 32'(frame_done), 32'(c == n * t - 1));
      step();
    end
    check("idle_txd", 32'(txd), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tready", 32'(s_axis_tready), 32'd1);
  endtask

  initial begin
    int s0, s1, s2, fd_cnt, low_cnt;

    // reset state
    step(); step(); step();
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    check("rst_tready_release_cycle", 32'(s_axis_tready), 32'd0);
    step();
    check("tready_after_rst", 32'(s_axis_tready), 32'd1);

    // 8N1 0xA5 at prescale 1
    send_frame(8'hA5, 0, 1'b0, 1, 1'b0, s0);
    // even then odd parity on 0x07 at prescale 2
    send_frame(8'h07, 1, 1'b0, 2, 1'b0, s0);
    send_frame(8'h07, 2, 1'b0, 2, 1'b0, s0);
    // mark and space parity
    send_frame(8'h3C, 3, 1'b0, 1, 1'b0, s0);
    send_frame(8'hC3, 4, 1'b1, 1, 1'b0, s0);

    // back-to-back with two stop bits and tvalid held high
    send_frame(DW'($urandom), 0, 1'b1, 1, 1'b1, s0);
    send_frame(DW'($urandom), 0, 1'b1, 1, 1'b1, s1);
    send_frame(DW'($urandom), 0, 1'b1, 1, 1'b0, s2);
    check("b2b_gap_01", 32'(s1 - s0), 32'd89);
    check("b2b_gap_12", 32'(s2 - s1), 32'd89);

    // prescale 0 behaves as 1
    send_frame(8'h5A, 0, 1'b0, 0, 1'b0, s0);
    send_frame(8'h81, 1, 1'b1, 0, 1'b0, s0);

    // randomized frames, including reserved parity codes 5..7
    for (int k = 0; k < 8; k++)
      send_frame(DW'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom), s0);
    s_axis_tvalid = 1'b0;
    step();

    // reset in the middle of data bit 3
    s_axis_tdata = 8'hFF; cfg_parity = 3'd0; cfg_stop2 = 1'b0; prescale = PW'(1);
    s_axis_tvalid = 1'b1;
    check("mid_rst_ready", 32'(s_axis_tready), 32'd1);
    step();
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 8 * 4 + 2; i++) step();
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_tready_release", 32'(s_axis_tready), 32'd1);
    fd_cnt = 0; low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (txd !== 1'b1) low_cnt++;
      step();
    end
    check("mid_rst_no_frame_done", 32'(fd_cnt), 32'd0);
    check("mid_rst_txd_idle", 32'(low_cnt), 32'd0);
    send_frame(8'h96, 2, 1'b0, 1, 1'b0, s0);

`ifdef UART_TX_BREAK_EN
    // break for 50 cycles with a word pending in the same cycle
    s_axis_tdata = 8'h3C; cfg_parity = 3'd0; cfg_stop2 = 1'b0; prescale = PW'(1);
    s_axis_tvalid = 1'b1;
    break_req = 1'b1;
    check("brk_tready_c0", 32'(s_axis_tready), 32'd0);
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 50) break_req = 1'b0;
      check($sformatf("brk_txd c=%0d", i), 32'(txd), 32'd0);
      check($sformatf("brk_busy c=%0d", i), 32'(busy), 32'd1);
      check($sformatf("brk_tready c=%0d", i), 32'(s_axis_tready), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("mab_txd c=%0d", i), 32'(txd), 32'd1);
      check($sformatf("mab_tready c=%0d", i), 32'(s_axis_tready), 32'd0);
      check($sformatf("mab_frame_done c=%0d", i), 32'(frame_done), 32'd0);
    end
    step();
    check("brk_tready_after_mab", 32'(s_axis_tready), 32'd1);
    send_frame(8'h3C, 0, 1'b0, 1, 1'b0, s0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
